// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The top and the next-PC selector both import this package.
package pc_fetch_unit_pkg;

    // Default datapath widths.
    localparam int DEFAULT_NB_DATA = 32;
    localparam int DEFAULT_NB_PC   = 12;

    // Opcode that stops fetching once it reaches the IF/ID register.
    localparam logic [5:0] DEFAULT_HALT_OPCODE = 6'b111111;

    // Position of the opcode field inside an instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // All-zero word inserted into IF/ID when a redirect flushes the stage.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Fetch control states. HALTED is left only through reset.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // True when the opcode field of a word matches the halt opcode.
    function automatic logic is_halt_word(input logic [31:0] word,
                                          input logic [5:0]  halt_opcode);
        return (word[OPCODE_MSB:OPCODE_LSB] == halt_opcode);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Combinational next-PC selector for the fetch stage.
// Resolves the per-cycle priority between hold conditions, redirects,
// stall and sequential advance. It also reports which action was taken,
// so the top can update IF/ID and the FSM consistently.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter int NB_PC = DEFAULT_NB_PC
) (
    input  logic [NB_PC-1:0] i_pc,
    input  logic             i_halted,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [NB_PC-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NB_PC-1:0] i_jump_target,
    output logic [NB_PC-1:0] o_pc_next,
    output logic [NB_PC-1:0] o_pc_plus4,
    output logic             o_redirect,
    output logic             o_advance
);

    logic [NB_PC-1:0] branch_aligned;
    logic [NB_PC-1:0] jump_aligned;

    // Word-align the redirect targets so the PC low bits stay zero.
    always_comb begin
        branch_aligned = {i_branch_target[NB_PC-1:2], 2'b00};
        jump_aligned   = {i_jump_target[NB_PC-1:2], 2'b00};
    end

    // Priority select: halted/disabled hold, then branch, jump, stall, sequential.
    always_comb begin
        o_pc_plus4 = i_pc + NB_PC'(4);
        o_pc_next  = i_pc;
        o_redirect = 1'b0;
        o_advance  = 1'b0;
        if (!i_halted && i_enable) begin
            if (i_branch_taken) begin
                o_pc_next  = branch_aligned;
                o_redirect = 1'b1;
            end else if (i_jump) begin
                o_pc_next  = jump_aligned;
                o_redirect = 1'b1;
            end else if (!i_stall) begin
                o_pc_next  = o_pc_plus4;
                o_advance  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and
// the RUN/HALTED control FSM. Next-PC selection lives in pc_next_mux.
// Instruction memory answers on the falling edge, so i_instruction is the
// word at o_pc by the next rising edge.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int         NB_DATA     = DEFAULT_NB_DATA,
    parameter int         NB_PC       = DEFAULT_NB_PC,
    parameter logic [5:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [NB_PC-1:0]   i_branch_target,
    input  logic               i_jump,
    input  logic [NB_PC-1:0]   i_jump_target,
    input  logic [NB_DATA-1:0] i_instruction,
    output logic [NB_PC-1:0]   o_pc,
    output logic [NB_DATA-1:0] o_if_id_instr,
    output logic [NB_PC-1:0]   o_if_id_pc_plus4,
    output logic               o_halted
);

    fetch_state_e      state_q, state_d;
    logic              halted_q, halted_d;
    logic [NB_PC-1:0]  pc_q, pc_d;
    logic [NB_DATA-1:0] if_id_instr_q, if_id_instr_d;
    logic [NB_PC-1:0]  if_id_pc_plus4_q, if_id_pc_plus4_d;

    logic [NB_PC-1:0]  pc_next;
    logic [NB_PC-1:0]  pc_plus4;
    logic              redirect;
    logic              advance;
    logic              fetched_halt;

    pc_next_mux #(
        .NB_PC (NB_PC)
    ) u_pc_next_mux (
        .i_pc            (pc_q),
        .i_halted        (state_q == ST_HALTED),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .o_pc_next       (pc_next),
        .o_pc_plus4      (pc_plus4),
        .o_redirect      (redirect),
        .o_advance       (advance)
    );

    // Detect a halt opcode in the word being fetched this cycle.
    always_comb begin
        fetched_halt = is_halt_word(i_instruction[31:0], HALT_OPCODE);
    end

    // Next values for PC, IF/ID and FSM; redirects flush, advances capture,
    // and a halt word only takes effect when it is actually captured.
    always_comb begin
        pc_d             = pc_next;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        state_d          = state_q;
        if (redirect) begin
            if_id_instr_d    = NB_DATA'(NOP_WORD);
            if_id_pc_plus4_d = '0;
        end else if (advance) begin
            if_id_instr_d    = i_instruction;
            if_id_pc_plus4_d = pc_plus4;
            if (fetched_halt) begin
                state_d = ST_HALTED;
            end
        end
        halted_d = (state_d == ST_HALTED);
    end

    // All fetch state, with synchronous active-low reset overriding everything.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q          <= ST_RUN;
            halted_q         <= 1'b0;
            pc_q             <= '0;
            if_id_instr_q    <= '0;
            if_id_pc_plus4_q <= '0;
        end else begin
            state_q          <= state_d;
            halted_q         <= halted_d;
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        o_pc             = pc_q;
        o_if_id_instr    = if_id_instr_q;
        o_if_id_pc_plus4 = if_id_pc_plus4_q;
        o_halted         = halted_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with a behavioural fetch model.
module tb_pc_fetch_unit;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        branchTaken;
    logic [11:0] branchTarget;
    logic        jump;
    logic [11:0] jumpTarget;
    logic [31:0] instruction;
    logic [11:0] pc;
    logic [31:0] ifIdInstr;
    logic [11:0] ifIdPcPlus4;
    logic        halted;

    logic [31:0] mem [0:1023];

    int          mPc;
    logic [31:0] mInstr;
    int          mPcPlus4;
    logic        mHalted;

    int checkCount;
    int passCount;

    pc_fetch_unit #(
        .NB_DATA     (32),
        .NB_PC       (12),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_enable         (enable),
        .i_stall          (stall),
        .i_branch_taken   (branchTaken),
        .i_branch_target  (branchTarget),
        .i_jump           (jump),
        .i_jump_target    (jumpTarget),
        .i_instruction    (instruction),
        .o_pc             (pc),
        .o_if_id_instr    (ifIdInstr),
        .o_if_id_pc_plus4 (ifIdPcPlus4),
        .o_halted         (halted)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction memory model: word at the current fetch address.
    always_comb begin
        instruction = mem[pc[11:2]];
    end

    // Compare one value and keep the counters.
    task automatic expectEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        assert (actual === expected) passCount++;
        else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Compare all DUT outputs against the model.
    task automatic checkOutput(input string tag);
        expectEq({tag, ".pc"},     32'(pc),          32'(mPc));
        expectEq({tag, ".instr"},  ifIdInstr,        mInstr);
        expectEq({tag, ".pc4"},    32'(ifIdPcPlus4), 32'(mPcPlus4));
        expectEq({tag, ".halted"}, 32'(halted),      32'(mHalted));
    endtask

    // Drive one cycle of inputs, advance the model, then check.
    task automatic applyStimulus(input string tag, input logic rst, input logic en, input logic stl,
                                 input logic br, input logic [11:0] bt,
                                 input logic jmp, input logic [11:0] jt);
        int          nPc;
        logic [31:0] nInstr;
        int          nPcPlus4;
        logic        nHalted;
        logic [31:0] word;
        @(negedge clock);
        reset        = rst;
        enable       = en;
        stall        = stl;
        branchTaken  = br;
        branchTarget = bt;
        jump         = jmp;
        jumpTarget   = jt;
        nPc      = mPc;
        nInstr   = mInstr;
        nPcPlus4 = mPcPlus4;
        nHalted  = mHalted;
        if (!rst) begin
            nPc = 0; nInstr = 0; nPcPlus4 = 0; nHalted = 1'b0;
        end else if (mHalted || !en) begin
            // everything holds
        end else if (br || jmp) begin
            nPc      = br ? (int'(bt) / 4) * 4 : (int'(jt) / 4) * 4;
            nInstr   = 32'h0;
            nPcPlus4 = 0;
        end else if (!stl) begin
            word     = mem[mPc / 4];
            nInstr   = word;
            nPcPlus4 = (mPc + 4) % 4096;
            nPc      = nPcPlus4;
            if ((word >> 26) == 32'd63) nHalted = 1'b1;
        end
        @(posedge clock);
        #1;
        mPc = nPc; mInstr = nInstr; mPcPlus4 = nPcPlus4; mHalted = nHalted;
        checkOutput(tag);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        mPc = 0; mInstr = 0; mPcPlus4 = 0; mHalted = 1'b0;
        reset = 1'b0; enable = 1'b0; stall = 1'b0;
        branchTaken = 1'b0; branchTarget = '0; jump = 1'b0; jumpTarget = '0;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom() & 32'hFBFF_FFFF;
        mem[0] = 32'h1;
        mem[1] = 32'h2;
        mem[2] = 32'h3;
        mem[3] = 32'h4;

        // Reset with noisy control inputs.
        applyStimulus("reset0", 1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 1'b1, 12'h456);
        applyStimulus("reset1", 1'b0, 1'b1, 1'b0, 1'b0, 12'h0,   1'b0, 12'h0);
        expectEq("reset.pc", 32'(pc), 32'h0);

        // Sequential fetch from address 0.
        applyStimulus("seq0", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("seq0.instr", ifIdInstr, 32'h1);
        applyStimulus("seq1", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("seq1.pc", 32'(pc), 32'h8);

        // Stall three cycles at PC 8, then resume.
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 1'b1, 1'b1, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("stall.instr", ifIdInstr, 32'h2);
        applyStimulus("resume", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("resume.pc", 32'(pc), 32'hC);
        expectEq("resume.pc4", 32'(ifIdPcPlus4), 32'hC);

        // Enable low holds everything.
        applyStimulus("disable", 1'b1, 1'b0, 1'b0, 1'b1, 12'h200, 1'b0, 12'h0);

        // Branch and jump together with stall: branch wins.
        applyStimulus("brjmp", 1'b1, 1'b1, 1'b1, 1'b1, 12'h040, 1'b1, 12'h080);
        expectEq("brjmp.pc", 32'(pc), 32'h40);
        applyStimulus("jmponly", 1'b1, 1'b1, 1'b1, 1'b0, 12'h040, 1'b1, 12'h082);
        expectEq("jmponly.pc", 32'(pc), 32'h80);

        // Randomized run with no halt words in memory.
        for (int i = 0; i < 200; i++) begin
            applyStimulus("rand",
                ($urandom_range(0, 49) != 0),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), 12'($urandom()),
                ($urandom_range(0, 7) == 0), 12'($urandom()));
        end

        // Wrap at the top of the address space, then an unaligned branch.
        applyStimulus("toTop", 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0, 12'h0);
        expectEq("toTop.pc", 32'(pc), 32'hFFC);
        applyStimulus("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("wrap.pc", 32'(pc), 32'h0);
        expectEq("wrap.pc4", 32'(ifIdPcPlus4), 32'h0);
        applyStimulus("unaligned", 1'b1, 1'b1, 1'b0, 1'b1, 12'h043, 1'b0, 12'h0);
        expectEq("unaligned.pc", 32'(pc), 32'h40);

        // Halt word at 0x10: redirect suppresses it, then it is captured.
        mem[4] = 32'hFC00_0000;
        applyStimulus("hreset", 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        for (int i = 0; i < 4; i++)
            applyStimulus("hseq", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        applyStimulus("hsuppress", 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 1'b0, 12'h0);
        expectEq("hsuppress.halted", 32'(halted), 32'h0);
        applyStimulus("hcapture", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("hcapture.halted", 32'(halted), 32'h1);
        expectEq("hcapture.pc", 32'(pc), 32'h14);
        expectEq("hcapture.instr", ifIdInstr, 32'hFC00_0000);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("hfrozen", 1'b1, 1'b1,
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), 12'($urandom()),
                ($urandom_range(0, 1) == 1), 12'($urandom()));
        end
        expectEq("hfrozen.pc", 32'(pc), 32'h14);

        // Reset while halted with a branch pending.
        applyStimulus("hexit", 1'b0, 1'b1, 1'b0, 1'b1, 12'h300, 1'b0, 12'h0);
        expectEq("hexit.halted", 32'(halted), 32'h0);
        applyStimulus("restart", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
        expectEq("restart.instr", ifIdInstr, 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, instruction word width.
REQ-002 SHALL have parameter NB_PC, default 12, byte-address width driven to instruction memory.
REQ-003 SHALL have parameter HALT_OPCODE, default 6'b111111, opcode field value that halts fetch.
REQ-004 SHALL have port i_clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port i_enable  in  1  global run/step enable from debug unit.
REQ-007 SHALL have port i_stall  in  1  hazard stall; hold PC and IF/ID.
REQ-008 SHALL have port i_branch_taken  in  1  branch redirect request.
REQ-009 SHALL have port i_branch_target  in  NB_PC  branch byte address.
REQ-010 SHALL have port i_jump  in  1  jump redirect request.
REQ-011 SHALL have port i_jump_target  in  NB_PC  jump byte address.
REQ-012 SHALL have port i_instruction  in  NB_DATA  word returned by instruction memory for o_pc.
REQ-013 SHALL have port o_pc  out  NB_PC  current fetch byte address to instruction memory.
REQ-014 SHALL have port o_if_id_instr  out  NB_DATA  IF/ID registered instruction.
REQ-015 SHALL have port o_if_id_pc_plus4  out  NB_PC  IF/ID registered PC+4.
REQ-016 SHALL have port o_halted  out  1  high while FSM is HALTED.

Function
REQ-017 SHALL hold PC register; o_pc driven directly from it; bits [1:0] always 0.
REQ-018 SHALL treat i_instruction as valid for o_pc before the next rising edge (memory reads on falling edge).
REQ-019 SHALL implement FSM states RUN, HALTED; RUN->HALTED on IF/ID capture of word whose bits [31:26] equal HALT_OPCODE; HALTED exits only on reset.
REQ-020 SHALL update per edge with priority: reset > HALTED (hold all) > !i_enable (hold all) > branch > jump > stall > sequential.
REQ-021 Branch: PC <= i_branch_target with [1:0] forced 0; IF/ID instr <= 0 (NOP flush); IF/ID pc_plus4 <= 0.
REQ-022 Jump (no branch): same as REQ-021 using i_jump_target.
REQ-023 Branch and jump same cycle: branch wins, jump ignored.
REQ-024 Redirect with i_stall high: redirect wins, stall ignored that cycle.
REQ-025 Stall (no redirect): PC, IF/ID, FSM state unchanged.
REQ-026 Sequential: PC <= PC+4 modulo 2^NB_PC (0x...FFC wraps to 0); IF/ID instr <= i_instruction; IF/ID pc_plus4 <= PC+4.
REQ-027 Halt word captured into IF/ID; PC advances once past it, then freezes; redirect same cycle suppresses halt capture.
REQ-028 Latency: fetch address to IF/ID output one cycle; redirect to new-target instruction in IF/ID two cycles.

Reset
REQ-029 SHALL, while i_reset==0 at a rising edge: PC=0, o_if_id_instr=0, o_if_id_pc_plus4=0, FSM=RUN, o_halted=0.
REQ-030 Reset mid-stall, mid-redirect or in HALTED SHALL override all other inputs that edge.
REQ-031 First post-reset edge with i_enable=1 SHALL capture word at address 0.

Structure
REQ-032 Shared package SHALL hold NB_DATA, NB_PC, HALT_OPCODE, opcode field bounds [31:26], NOP word value, FSM state encoding.
REQ-033 Sub-module pc_next_mux SHALL compute next PC (combinational priority select, REQ-020..026); FSM and IF/ID register stay in top.

Verification
REQ-034 Reset released, enable=1, memory words 0x1,0x2,0x3 at 0,4,8 -> o_pc 0,4,8,0xC; IF/ID instr 0x1,0x2,0x3; pc_plus4 4,8,0xC.
REQ-035 Stall 3 cycles at PC=8 -> o_pc stays 8, IF/ID unchanged 3 cycles, then resumes 0xC.
REQ-036 Branch_taken=1 target 0x40 and jump=1 target 0x80 same edge with stall=1 -> o_pc=0x40, IF/ID instr=0, pc_plus4=0.
REQ-037 Halt word 0xFC000000 at 0x10 -> captured in IF/ID, o_halted=1, o_pc freezes at 0x14 regardless of branch/jump/stall.
REQ-038 PC at 0xFFC (NB_PC=12) sequential -> o_pc=0x000, pc_plus4=0x000; branch target 0x43 -> o_pc=0x40.
REQ-039 i_reset low while HALTED with branch asserted -> next edge o_pc=0, o_halted=0, IF/ID cleared.
